alu_arbiter: RTL and testbench

//  Shares one combinational ALU (x,y,op -> r,zero) between two requesters,
//  e.g. the calculator front-end and the processor execute stage. Accepts

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight; each result is held until its owner takes it.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_r,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_r,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  output logic             grant,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             grant_q, grant_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [WIDTH-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp0_r_q, rsp0_r_d, rsp1_r_q, rsp1_r_d;
  logic             rsp0_zero_q, rsp0_zero_d, rsp1_zero_q, rsp1_zero_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; ready never depends on ready of the other side.
  logic any_req, win;
  assign any_req = req0_valid | req1_valid;
  assign win     = (req0_valid & req1_valid) ? prio_q : req1_valid;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    grant_d     = grant_q;
    lat_d       = lat_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    alu_op_d    = alu_op_q;
    rsp0_r_d    = rsp0_r_q;
    rsp0_zero_d = rsp0_zero_q;
    rsp1_r_d    = rsp1_r_q;
    rsp1_zero_d = rsp1_zero_q;
    cnt_d       = cnt_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req0_ready = ~win;
          req1_ready = win;
          alu_x_d    = win ? req1_x  : req0_x;
          alu_y_d    = win ? req1_y  : req0_y;
          alu_op_d   = win ? req1_op : req0_op;
          grant_d    = win;
          lat_d      = LW'(ALU_LAT - 1);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (lat_q == '0) begin
          if (grant_q) begin
            rsp1_r_d    = alu_r;
            rsp1_zero_d = alu_zero;
          end else begin
            rsp0_r_d    = alu_r;
            rsp0_zero_d = alu_zero;
          end
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP: begin
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          cnt_d   = cnt_q + 1'b1;
          prio_d  = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      grant_q     <= 1'b0;
      lat_q       <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_op_q    <= '0;
      rsp0_r_q    <= '0;
      rsp0_zero_q <= 1'b0;
      rsp1_r_q    <= '0;
      rsp1_zero_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      grant_q     <= grant_d;
      lat_q       <= lat_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_op_q    <= alu_op_d;
      rsp0_r_q    <= rsp0_r_d;
      rsp0_zero_q <= rsp0_zero_d;
      rsp1_r_q    <= rsp1_r_d;
      rsp1_zero_q <= rsp1_zero_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) & ~grant_q;
  assign rsp1_valid = (state_q == RESP) &  grant_q;
  assign rsp0_r     = rsp0_r_q;
  assign rsp0_zero  = rsp0_zero_q;
  assign rsp1_r     = rsp1_r_q;
  assign rsp1_zero  = rsp1_zero_q;
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign alu_op     = alu_op_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: the ALU lives here, and a transaction-level model
// predicts every output each cycle from arrival times and captured operands.
module tb_alu_arbiter;
  localparam int W   = 32;
  localparam int OW  = 3;
  localparam int LAT = 3;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_x, req0_y, req1_x, req1_y;
  logic [OW-1:0] req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [W-1:0]  rsp0_r, rsp1_r;
  logic [W-1:0]  alu_x, alu_y, alu_r;
  logic [OW-1:0] alu_op;
  logic          alu_zero, grant, busy;
  logic [CW-1:0] op_count;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [OW-1:0] op);
    case (op)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      default: return x ^ y;
    endcase
  endfunction

  assign alu_r    = alu_f(alu_x, alu_y, alu_op);
  assign alu_zero = (alu_r == '0);

  alu_arbiter #(.WIDTH(W), .OPW(OW), .ALU_LAT(LAT), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r), .rsp1_zero(rsp1_zero),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_r(alu_r), .alu_zero(alu_zero),
    .grant(grant), .busy(busy), .op_count(op_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: one operation outstanding, result due 1+LAT cycles after acceptance.
  int            cyc;
  bit            m_idle, m_owner, m_prio;
  int            m_acc, m_cnt;
  logic [W-1:0]  m_x, m_y;
  logic [OW-1:0] m_op;
  logic [W-1:0]  m_r[2];
  logic          m_z[2];
  bit            hs0, hs1;

  task automatic model_reset();
    m_idle = 1; m_owner = 0; m_prio = 0; m_acc = 0; m_cnt = 0;
    m_x = '0; m_y = '0; m_op = '0;
    m_r[0] = '0; m_r[1] = '0; m_z[0] = 1'b0; m_z[1] = 1'b0;
  endtask

  task automatic tick();
    int win;
    bit resp_phase;
    #1;
    if (!m_idle && cyc == m_acc + 1 + LAT) begin
      m_r[m_owner] = alu_f(m_x, m_y, m_op);
      m_z[m_owner] = (m_r[m_owner] == '0);
    end
    resp_phase = !m_idle && (cyc >= m_acc + 1 + LAT);
    win = -1;
    if (m_idle) begin
      if (req0_valid && req1_valid) win = int'(m_prio);
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
    end
    check("req0_ready", W'(req0_ready), W'(win == 0));
    check("req1_ready", W'(req1_ready), W'(win == 1));
    check("rsp0_valid", W'(rsp0_valid), W'(resp_phase && !m_owner));
    check("rsp1_valid", W'(rsp1_valid), W'(resp_phase && m_owner));
    check("rsp0_r", rsp0_r, m_r[0]);
    check("rsp0_zero", W'(rsp0_zero), W'(m_z[0]));
    check("rsp1_r", rsp1_r, m_r[1]);
    check("rsp1_zero", W'(rsp1_zero), W'(m_z[1]));
    check("alu_x", alu_x, m_x);
    check("alu_y", alu_y, m_y);
    check("alu_op", W'(alu_op), W'(m_op));
    check("grant", W'(grant), W'(m_owner));
    check("busy", W'(busy), W'(!m_idle));
    check("op_count", W'(op_count), W'(m_cnt % (1 << CW)));
    hs0 = (win == 0);
    hs1 = (win == 1);
    if (rst) model_reset();
    else if (win >= 0) begin
      m_x = win ? req1_x : req0_x;
      m_y = win ? req1_y : req0_y;
      m_op = win ? req1_op : req0_op;
      m_owner = (win == 1);
      m_idle = 0;
      m_acc = cyc;
    end else if (resp_phase && (m_owner ? rsp1_ready : rsp0_ready)) begin
      m_cnt++;
      m_prio = !m_owner;
      m_idle = 1;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    if (hs0) req0_valid = 1'b0;
    if (hs1) req1_valid = 1'b0;
  endtask

  task automatic drive0(input logic [W-1:0] x, input logic [W-1:0] y, input logic [OW-1:0] op);
    req0_x = x; req0_y = y; req0_op = op; req0_valid = 1'b1;
  endtask

  task automatic drive1(input logic [W-1:0] x, input logic [W-1:0] y, input logic [OW-1:0] op);
    req1_x = x; req1_y = y; req1_op = op; req1_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!req0_valid && !req1_valid && m_idle) begin
        done = 1;
        break;
      end
      tick();
    end
    check("drain_timeout", W'(done), W'(1));
  endtask

  function automatic logic [OW-1:0] rand_op();
    logic [OW-1:0] ops[4];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110;
    return ops[$urandom_range(0, 3)];
  endfunction

  initial begin
    logic [W-1:0] rx;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_x = '0; req0_y = '0; req0_op = '0;
    req1_x = '0; req1_y = '0; req1_op = '0;
    cyc = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single ADD from requester 0
    rsp0_ready = 1'b1;
    drive0(32'h1, 32'h10, 3'b010);
    drain();
    check("t1_result", rsp0_r, 32'h11);
    check("t1_count", W'(op_count), W'(1));

    // simultaneous requests after reset: prio starts at requester 0
    do_reset();
    drive0(32'h1, 32'h1, 3'b000);
    drive1(32'h2, 32'h1, 3'b110);
    drain();
    check("t2_r1", rsp1_r, 32'h1);

    // SUB to zero from requester 1
    drive1(32'h5, 32'h5, 3'b110);
    drain();
    check("t3_zero", W'(rsp1_zero), W'(1));

    // requester 0 stalls its response while requester 1 waits
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    drive0(32'hdead_0000, 32'h0000_beef, 3'b001);
    drive1(32'h7, 32'h3, 3'b010);
    for (int i = 0; i < 1 + LAT + 5; i++) begin
      if (i == 2) begin req0_x = $urandom; req0_y = $urandom; end
      tick();
    end
    drain();

    // reset while executing abandons the operation
    rsp0_ready = 1'b1;
    drive0(32'h3, 32'h4, 3'b010);
    tick();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // op_count wraps after 16 completions
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i % 2 == 0) drive0($urandom, $urandom, rand_op());
      else drive1($urandom, $urandom, rand_op());
      drain();
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        rx = $urandom;
        drive0(rx, ($urandom_range(0, 3) == 0) ? rx : $urandom, rand_op());
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        rx = $urandom;
        drive1(rx, ($urandom_range(0, 3) == 0) ? rx : $urandom, rand_op());
      end
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
